// File: rtl/uart_tx_prescaled.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Each bit lasts Prescale cycles (0 means 16). Line idles high.
module uart_tx_prescaled #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK_UART_TX,
   input  logic                  RST_UART_TX,
   input  logic [DATA_WIDTH-1:0] P_DATA_UART_TX,
   input  logic                  DATA_VALID_UART_TX,
   input  logic                  PAR_EN_UART_TX,
   input  logic                  PAR_TYPE_UART_TX,
   input  logic [3:0]            Prescale_UART_TX,
   output logic                  TX_OUT_UART_TX,
   output logic                  BUSY_UART_TX
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   localparam logic [2:0] LAST_IDX = 3'(DATA_WIDTH - 1);

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [2:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic [3:0]            last_q, last_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  tick_end;

   // last_q holds P-1; a Prescale of 0 wraps to 15, giving 16 cycles
   assign tick_end = (cnt_q == last_q);

   // Next-state, bit timing and next line level decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = tick_end ? 4'd0 : cnt_q + 4'd1;
      idx_d     = idx_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      last_d    = last_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      unique case (state_q)
         IDLE: begin
            cnt_d  = 4'd0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (DATA_VALID_UART_TX) begin
               data_d    = P_DATA_UART_TX;
               par_en_d  = PAR_EN_UART_TX;
               par_bit_d = (^P_DATA_UART_TX) ^ PAR_TYPE_UART_TX;
               last_d    = Prescale_UART_TX - 4'd1;
               state_d   = START;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
            end
         end
         START: begin
            if (tick_end) begin
               state_d = DATA;
               idx_d   = 3'd0;
               tx_d    = data_q[0];
            end
         end
         DATA: begin
            if (tick_end) begin
               if (idx_q == LAST_IDX) begin
                  if (par_en_q) begin
                     state_d = PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = data_q[idx_q + 3'd1];
               end
            end
         end
         PARITY: begin
            if (tick_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (tick_end) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counters, latched frame and registered outputs
   always_ff @(posedge CLK_UART_TX or posedge RST_UART_TX) begin
      if (RST_UART_TX) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= 3'd0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         last_q    <= 4'd0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         last_q    <= last_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign TX_OUT_UART_TX = tx_q;
   assign BUSY_UART_TX   = busy_q;

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Directed bench for uart_tx_prescaled: every cycle of each
// frame is compared against a hand-computed bit sequence.
module tb_uart_tx_prescaled;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       valid;
   logic       par_en;
   logic       par_type;
   logic [3:0] prescale;
   logic       tx;
   logic       busy;

   int checks = 0;
   int errors = 0;

   uart_tx_prescaled dut (
      .CLK_UART_TX       (clk),
      .RST_UART_TX       (rst),
      .P_DATA_UART_TX    (p_data),
      .DATA_VALID_UART_TX(valid),
      .PAR_EN_UART_TX    (par_en),
      .PAR_TYPE_UART_TX  (par_type),
      .Prescale_UART_TX  (prescale),
      .TX_OUT_UART_TX    (tx),
      .BUSY_UART_TX      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Drive one request; returns at the negedge after acceptance
   task automatic send(input logic [7:0] d, input logic pe,
                       input logic pt, input logic [3:0] pre);
      @(negedge clk);
      p_data   = d;
      par_en   = pe;
      par_type = pt;
      prescale = pre;
      valid    = 1'b1;
      @(negedge clk);
      valid    = 1'b0;
   endtask

   // bits[0] is the start bit; called at cycle 0 of the frame
   task automatic check_frame(input string tag,
                              input logic [10:0] bits,
                              input int nbits, input int p);
      for (int k = 0; k < nbits * p; k++) begin
         if (k > 0) @(negedge clk);
         chk({tag, "_tx"}, 32'(tx), 32'(bits[k / p]));
         chk({tag, "_busy"}, 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
      chk({tag, "_end_tx"}, 32'(tx), 32'd1);
   endtask

   task automatic check_idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_busy"}, 32'(busy), 32'd0);
         chk({tag, "_tx"}, 32'(tx), 32'd1);
      end
   endtask

   initial begin
      rst      = 1'b1;
      p_data   = 8'h00;
      valid    = 1'b0;
      par_en   = 1'b0;
      par_type = 1'b0;
      prescale = 4'd8;
      repeat (2) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      check_idle("idle0", 2);

      // 0x39, P=8, even parity: 0,10011100,0,1
      send(8'h39, 1'b1, 1'b0, 4'd8);
      check_frame("f1", 11'h472, 11, 8);
      check_idle("idle1", 2);

      // odd parity flips only the parity bit
      send(8'h39, 1'b1, 1'b1, 4'd8);
      check_frame("f2", 11'h672, 11, 8);
      check_idle("idle2", 2);

      // 0xA5, P=4, no parity: 0,10100101,1
      send(8'hA5, 1'b0, 1'b0, 4'd4);
      check_frame("f3", 11'h34A, 10, 4);
      check_idle("idle3", 2);

      // mid-frame request and config changes are ignored
      send(8'h39, 1'b1, 1'b0, 4'd8);
      fork
         check_frame("f4", 11'h472, 11, 8);
         begin
            repeat (20) @(negedge clk);
            valid    = 1'b1;
            p_data   = 8'hFF;
            par_type = 1'b1;
            prescale = 4'd3;
            repeat (40) @(negedge clk);
            valid    = 1'b0;
         end
      join
      check_idle("idle4", 4);
      par_type = 1'b0;
      prescale = 4'd8;

      // asynchronous reset in the middle of the data bits
      send(8'h39, 1'b1, 1'b0, 4'd8);
      repeat (30) @(negedge clk);
      chk("f5_pre_tx", 32'(tx), 32'd0);
      chk("f5_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("f5_async_tx", 32'(tx), 32'd1);
      chk("f5_async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      check_idle("idle5", 3);

      // 0x55, P=3, even parity: 0,10101010,0,1
      send(8'h55, 1'b1, 1'b0, 4'd3);
      check_frame("f5", 11'h4AA, 11, 3);
      check_idle("idle5b", 2);

      // Prescale 0 = 16, valid held: one idle cycle between frames
      @(negedge clk);
      p_data   = 8'h00;
      par_en   = 1'b0;
      par_type = 1'b0;
      prescale = 4'd0;
      valid    = 1'b1;
      @(negedge clk);
      check_frame("f6a", 11'h200, 10, 16);
      @(negedge clk);
      check_frame("f6b", 11'h200, 10, 16);
      valid = 1'b0;
      check_idle("idle6", 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_prescaled.md
Name: uart_tx_prescaled

Overview:
UART transmitter that is the send-side counterpart of the UART_RX receiver. It runs on the same oversampled clock and uses the same Prescale, PAR_EN and PAR_TYPE semantics, so its output drives RX_IN_UART_RX directly. It accepts one byte per handshake and serialises it as: start bit, 8 data bits LSB first, optional parity bit, stop bit. Each bit is held for Prescale clock cycles.

Parameters:
DATA_WIDTH, 8, data bits per frame. Fixed at 8 for this release; counters are sized for 8.

Ports:
CLK_UART_TX  input  1  oversampled UART clock, same clock as the receiver.
RST_UART_TX  input  1  asynchronous, active-high reset.
P_DATA_UART_TX  input  8  byte to transmit; sampled on acceptance.
DATA_VALID_UART_TX  input  1  transmit request; accepted only when BUSY_UART_TX=0.
PAR_EN_UART_TX  input  1  1 = append parity bit; sampled on acceptance.
PAR_TYPE_UART_TX  input  1  0 = even, 1 = odd; sampled on acceptance.
Prescale_UART_TX  input  4  clock cycles per bit; 0 encodes 16; sampled on acceptance.
TX_OUT_UART_TX  output  1  serial line; idle high; registered.
BUSY_UART_TX  output  1  high while a frame is in progress; registered.

Behaviour:
- Reset (asynchronous, active-high): TX_OUT=1, BUSY=0, state=IDLE, all counters and latches cleared. A reset asserted mid-frame aborts the frame; the line returns high immediately and no partial bits resume.
- States are IDLE, START, DATA, PARITY, STOP. TX_OUT is driven from a register whose value is decoded from the next state, so it changes on the same edge as the state.
- IDLE: TX_OUT=1, BUSY=0. On a rising edge with DATA_VALID=1, the block:
  - latches the data byte, PAR_EN, PAR_TYPE and Prescale;
  - computes the parity bit = (XOR of the 8 data bits) XOR PAR_TYPE;
  - moves to START, setting TX_OUT=0 and BUSY=1 on that same edge.
- Bit timing: a 4-bit tick counter counts 0..P-1, where P = latched Prescale (0 -> 16). The state advances on the edge where the counter equals P-1; the counter then wraps to 0. Every bit therefore lasts exactly P cycles.
- START -> DATA: bit index resets to 0; TX_OUT = data[0].
- DATA: after each bit, the index increments and TX_OUT = data[index]. After bit 7, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: TX_OUT = computed parity bit; then go to STOP.
- STOP: TX_OUT=1 for P cycles. At the end of the stop bit, go to IDLE with BUSY=0.
- Frame length: 11·P cycles with parity, 10·P without, measured from the acceptance edge to the BUSY fall edge.
- DATA_VALID while BUSY=1 is ignored. It is not queued, and no error is flagged.
- Input changes mid-frame (data, parity config, Prescale) have no effect until the next acceptance.
- Back-to-back frames: the earliest next acceptance is the first edge after BUSY falls. The line therefore sits at 1 for at least P+1 cycles between frames, because stop plus one IDLE cycle is mandatory.
- DATA_VALID held high continuously produces frames separated by exactly one IDLE cycle.
- Only synthesisable constructs; no latches; a single clock domain.

Test Plan:
1. Reset; P=8, PAR_EN=1, PAR_TYPE=0, data=0x39, pulse DATA_VALID -> line sequence start 0, data bits 1,0,0,1,1,1,0,0, parity 0, stop 1. Each level lasts 8 cycles (88 cycles total), and BUSY is high for exactly 88 cycles. Looping TX_OUT into UART_RX (same settings) gives P_DATA=0x39 with data_valid asserted.
2. Same frame with PAR_TYPE=1 -> parity bit is 1; all other bits unchanged; receiver reports 0x39 valid.
3. P=4, PAR_EN=0, data=0xA5 -> 10 bits of 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1. BUSY is high for 40 cycles.
4. Start a frame with 0x39, then assert DATA_VALID with 0xFF at cycle 20 and change PAR_TYPE and Prescale mid-frame -> the transmitted frame is identical to scenario 1, and no second frame follows unless DATA_VALID is present after BUSY falls.
5. Assert RST mid-DATA, at cycle 30 of the frame -> TX_OUT=1 and BUSY=0 asynchronously, before the next clock edge. After release, a new request for 0x55 produces a clean full frame.
6. Prescale=0, PAR_EN=0, DATA_VALID held high with data 0x00 -> each bit lasts 16 cycles, frames are 160 cycles, and there is exactly one idle-high cycle between consecutive start bits' preceding stop bits.
